wb_regfile_unit: RTL



---
 rtl/wb_regfile_unit_if.sv | 41 ++++
 rtl/wb_regfile_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/wb_regfile_unit_if.sv
// MEM/WB handoff, decode read ports and writeback observation bundle for wb_regfile_unit.
interface wb_regfile_unit_if #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16
);
   localparam int AW   = $clog2(NREG);
   localparam int BO_W = $clog2(DATA_W / 8);

   logic              stall;
   logic              flush;
   logic              in_valid;
   logic [AW-1:0]     in_rd;
   logic              in_regwrite;
   logic [1:0]        in_wbsel;
   logic [DATA_W-1:0] in_alures;
   logic [DATA_W-1:0] in_rdata;
   logic [DATA_W-1:0] in_pcplus;
   logic [1:0]        in_ldsize;
   logic              in_ldsigned;
   logic [BO_W-1:0]   in_byteoff;
   logic [AW-1:0]     raddr_a;
   logic [AW-1:0]     raddr_b;
   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;
   logic              wb_we;
   logic [AW-1:0]     wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic [31:0]       retire_cnt;

   modport master (
      output stall, flush, in_valid, in_rd, in_regwrite, in_wbsel, in_alures,
             in_rdata, in_pcplus, in_ldsize, in_ldsigned, in_byteoff, raddr_a, raddr_b,
      input  rdata_a, rdata_b, wb_we, wb_rd, wb_data, retire_cnt
   );

   modport slave (
      input  stall, flush, in_valid, in_rd, in_regwrite, in_wbsel, in_alures,
             in_rdata, in_pcplus, in_ldsize, in_ldsigned, in_byteoff, raddr_a, raddr_b,
      output rdata_a, rdata_b, wb_we, wb_rd, wb_data, retire_cnt
   );
endinterface

// File: rtl/wb_regfile_unit.sv
// Writeback stage: stall/flush-aware WB latch, result select with sub-word load
// extraction, register file with write-through read bypass, and retire counter.
module wb_regfile_unit #(
   parameter int DATA_W   = 32,
   parameter int NREG     = 16,
   parameter int ZERO_REG = 1,
   parameter int AW       = $clog2(NREG),
   parameter int BO_W     = $clog2(DATA_W / 8)
) (
   input logic               clk,
   input logic               rst,
   wb_regfile_unit_if.slave  bus
);
   localparam int SW = $clog2(DATA_W);

   logic              v_q;
   logic              c_q;
   logic              rw_q;
   logic              lds_q;
   logic [AW-1:0]     rd_q;
   logic [1:0]        sel_q;
   logic [1:0]        lsz_q;
   logic [DATA_W-1:0] alu_q;
   logic [DATA_W-1:0] mem_q;
   logic [DATA_W-1:0] pc_q;
   logic [BO_W-1:0]   boff_q;
   logic [31:0]       retire_q;
   logic [DATA_W-1:0] regs [NREG];

   logic                     commit;
   logic                     we;
   logic [BO_W-1:0]          lane_off;
   logic [BO_W+2:0]          bit_sh;
   logic [SW-1:0]            keep_sh;
   logic [DATA_W-1:0]        shifted;
   logic [DATA_W-1:0]        left;
   logic signed [DATA_W-1:0] left_s;
   logic [DATA_W-1:0]        sext;
   logic [DATA_W-1:0]        ld_val;
   logic [DATA_W-1:0]        wb_val;

   assign commit = v_q & ~c_q;
   assign we     = commit & rw_q & ~((ZERO_REG != 0) && (rd_q == '0));

   // A stalled entry stays in the latch; committed keeps it from writing or counting twice.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q    <= 1'b0;
         c_q    <= 1'b0;
         rw_q   <= 1'b0;
         lds_q  <= 1'b0;
         rd_q   <= '0;
         sel_q  <= '0;
         lsz_q  <= '0;
         alu_q  <= '0;
         mem_q  <= '0;
         pc_q   <= '0;
         boff_q <= '0;
      end else if (bus.flush) begin
         v_q <= 1'b0;
         c_q <= 1'b0;
      end else if (bus.stall) begin
         if (commit)
            c_q <= 1'b1;
      end else begin
         v_q    <= bus.in_valid;
         c_q    <= 1'b0;
         rw_q   <= bus.in_regwrite;
         lds_q  <= bus.in_ldsigned;
         rd_q   <= bus.in_rd;
         sel_q  <= bus.in_wbsel;
         lsz_q  <= bus.in_ldsize;
         alu_q  <= bus.in_alures;
         mem_q  <= bus.in_rdata;
         pc_q   <= bus.in_pcplus;
         boff_q <= bus.in_byteoff;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         retire_q <= '0;
      else if (commit)
         retire_q <= retire_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (we) begin
         regs[rd_q] <= wb_val;
      end
   end

   // Move the selected lane to bit 0, then push it to the top and shift back to extend.
   always_comb begin
      lane_off = boff_q;
      keep_sh  = SW'(DATA_W - 8);
      case (lsz_q)
         2'b01: begin
            lane_off = boff_q & ~BO_W'(1);
            keep_sh  = SW'(DATA_W - 16);
         end
         2'b10: begin
            lane_off = boff_q & ~BO_W'(3);
            keep_sh  = SW'(DATA_W - 32);
         end
         2'b11: begin
            lane_off = '0;
            keep_sh  = '0;
         end
         default: ;
      endcase
      bit_sh  = {lane_off, 3'b000};
      shifted = mem_q >> bit_sh;
      left    = shifted << keep_sh;
      left_s  = left;
      sext    = left_s >>> keep_sh;
      ld_val  = lds_q ? sext : (left >> keep_sh);
   end

   always_comb begin
      case (sel_q)
         2'b01:   wb_val = ld_val;
         2'b10:   wb_val = pc_q;
         default: wb_val = alu_q;
      endcase
   end

   always_comb begin
      if ((ZERO_REG != 0) && (bus.raddr_a == '0))
         bus.rdata_a = '0;
      else if (we && (bus.raddr_a == rd_q))
         bus.rdata_a = wb_val;
      else
         bus.rdata_a = regs[bus.raddr_a];
   end

   always_comb begin
      if ((ZERO_REG != 0) && (bus.raddr_b == '0))
         bus.rdata_b = '0;
      else if (we && (bus.raddr_b == rd_q))
         bus.rdata_b = wb_val;
      else
         bus.rdata_b = regs[bus.raddr_b];
   end

   assign bus.wb_we      = we;
   assign bus.wb_rd      = rd_q;
   assign bus.wb_data    = wb_val;
   assign bus.retire_cnt = retire_q;
endmodule
